// File: rtl/dso_align_pkg.sv
// Shared types and counter widths for the frame-clock alignment controller.
package dso_align_pkg;

  typedef enum logic [2:0] {
    SEARCH,
    SLIP,
    SETTLE,
    VERIFY,
    LOCKED,
    FAIL
  } lane_state_e;

  // Widths cover the full legal ranges: SETTLE_CYC <= 255, LOCK_CNT/MISS_LIMIT <= 15.
  localparam int SETTLE_W   = 8;
  localparam int MATCH_W    = 4;
  localparam int MISS_W     = 4;
  localparam int SLIP_CNT_W = 4;
  localparam logic [SLIP_CNT_W-1:0] SLIP_CNT_MAX = '1;

  function automatic int tally_w(input int deser_w);
    return $clog2(deser_w + 1);
  endfunction

endpackage

// File: rtl/fclk_align_lane.sv
// Single frame lane: bitslip search, lock verification, lock monitoring and retrain.
module fclk_align_lane
  import dso_align_pkg::*;
#(
  parameter int                 DESER_W    = 8,
  parameter logic [DESER_W-1:0] PATTERN    = DESER_W'(8'h0F),
  parameter int                 SETTLE_CYC = 16,
  parameter int                 LOCK_CNT   = 4,
  parameter int                 MISS_LIMIT = 2
) (
  input  logic                  divclk,
  input  logic                  rst,
  input  logic                  retrain,
  input  logic [DESER_W-1:0]    frame,
  output logic                  bitslip,
  output logic                  lane_locked,
  output logic                  align_fail,
  output logic [SLIP_CNT_W-1:0] slip_count
);

  localparam int TALLY_W = tally_w(DESER_W);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [MATCH_W-1:0]  LOCK_TGT    = MATCH_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0]   MISS_TGT    = MISS_W'(MISS_LIMIT);
  localparam logic [TALLY_W-1:0]  TALLY_MAX   = TALLY_W'(DESER_W);

  lane_state_e           state, state_n;
  logic [MATCH_W-1:0]    match_cnt, match_n;
  logic [MISS_W-1:0]     miss_cnt, miss_n;
  logic [SETTLE_W-1:0]   settle_cnt, settle_n;
  logic [TALLY_W-1:0]    tally, tally_n;
  logic [SLIP_CNT_W-1:0] slips_n;
  logic [SETTLE_W-1:0]   gap_cnt;
  logic                  is_match, slip_ok;

  assign is_match = (frame == PATTERN);
  // A retrain can cut a settle short; the gap counter still enforces pulse spacing.
  assign slip_ok  = (gap_cnt == '0);

  // NOTE: every variable gets its default before the case so no latch is inferred.
  always_comb begin
    state_n  = state;
    match_n  = match_cnt;
    miss_n   = miss_cnt;
    settle_n = settle_cnt;
    tally_n  = tally;
    slips_n  = slip_count;
    case (state)
      SEARCH: begin
        if (is_match) begin
          if (LOCK_CNT == 1) begin
            state_n = LOCKED;
            miss_n  = '0;
          end else begin
            state_n = VERIFY;
            match_n = MATCH_W'(1);
          end
        end else if (slip_ok) begin
          state_n = SLIP;
        end
      end
      SLIP: begin
        settle_n = '0;
        state_n  = (tally == TALLY_MAX) ? FAIL : SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_n = SEARCH;
        else                           settle_n = settle_cnt + 1'b1;
      end
      VERIFY: begin
        if (is_match) begin
          if (match_cnt + 1'b1 == LOCK_TGT) begin
            state_n = LOCKED;
            miss_n  = '0;
          end else begin
            match_n = match_cnt + 1'b1;
          end
        end else begin
          state_n = slip_ok ? SLIP : SEARCH;
        end
      end
      LOCKED: begin
        if (is_match) begin
          miss_n = '0;
        end else if (miss_cnt + 1'b1 == MISS_TGT) begin
          state_n = SEARCH;
          miss_n  = '0;
          tally_n = '0;
          slips_n = '0;
        end else begin
          miss_n = miss_cnt + 1'b1;
        end
      end
      default: state_n = FAIL;
    endcase

    if (state_n == SLIP) begin
      tally_n = tally + 1'b1;
      if (slip_count != SLIP_CNT_MAX) slips_n = slip_count + 1'b1;
    end

    if (retrain) begin
      state_n  = SEARCH;
      match_n  = '0;
      miss_n   = '0;
      settle_n = '0;
      tally_n  = '0;
      slips_n  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge divclk) begin
    if (rst) begin
      state       <= SEARCH;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      settle_cnt  <= '0;
      tally       <= '0;
      gap_cnt     <= '0;
      slip_count  <= '0;
      bitslip     <= 1'b0;
      lane_locked <= 1'b0;
      align_fail  <= 1'b0;
    end else begin
      state       <= state_n;
      match_cnt   <= match_n;
      miss_cnt    <= miss_n;
      settle_cnt  <= settle_n;
      tally       <= tally_n;
      slip_count  <= slips_n;
      bitslip     <= (state_n == SLIP);
      lane_locked <= (state_n == LOCKED);
      align_fail  <= (state_n == FAIL);
      if (state == SLIP)      gap_cnt <= SETTLE_LAST;
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fclk_align_ctrl.sv
// Multi-ADC frame-clock alignment: one independent lane per ADC plus aggregate lock.
module fclk_align_ctrl
  import dso_align_pkg::*;
#(
  parameter int                 NUM_ADC    = 1,
  parameter int                 DESER_W    = 8,
  parameter logic [DESER_W-1:0] PATTERN    = DESER_W'(8'h0F),
  parameter int                 SETTLE_CYC = 16,
  parameter int                 LOCK_CNT   = 4,
  parameter int                 MISS_LIMIT = 2
) (
  input  logic                          divclk,
  input  logic                          rst,
  input  logic                          retrain,
  input  logic [NUM_ADC*DESER_W-1:0]    fclk_deser,
  output logic [NUM_ADC-1:0]            bitslip,
  output logic [NUM_ADC-1:0]            lane_locked,
  output logic                          all_locked,
  output logic [NUM_ADC-1:0]            align_fail,
  output logic [NUM_ADC*SLIP_CNT_W-1:0] slip_count
);

  for (genvar i = 0; i < NUM_ADC; i++) begin : g_lane
    fclk_align_lane #(
      .DESER_W    (DESER_W),
      .PATTERN    (PATTERN),
      .SETTLE_CYC (SETTLE_CYC),
      .LOCK_CNT   (LOCK_CNT),
      .MISS_LIMIT (MISS_LIMIT)
    ) u_lane (
      .divclk      (divclk),
      .rst         (rst),
      .retrain     (retrain),
      .frame       (fclk_deser[i*DESER_W +: DESER_W]),
      .bitslip     (bitslip[i]),
      .lane_locked (lane_locked[i]),
      .align_fail  (align_fail[i]),
      .slip_count  (slip_count[i*SLIP_CNT_W +: SLIP_CNT_W])
    );
  end

  always_ff @(posedge divclk) begin
    if (rst) all_locked <= 1'b0;
    else     all_locked <= &lane_locked;
  end

endmodule

// File: tb/tb_fclk_align_ctrl.sv
// Randomized and directed bench for fclk_align_ctrl against a per-lane behavioural model.
module tb_fclk_align_ctrl;
  localparam int NUM_ADC    = 2;
  localparam int DESER_W    = 8;
  localparam int SETTLE_CYC = 16;
  localparam int LOCK_CNT   = 4;
  localparam int MISS_LIMIT = 2;
  localparam logic [7:0] PATTERN = 8'h0F;

  logic                       divclk = 1'b0;
  logic                       rst, retrain;
  logic [NUM_ADC*DESER_W-1:0] fclk_deser;
  logic [NUM_ADC-1:0]         bitslip, lane_locked, align_fail;
  logic                       all_locked;
  logic [NUM_ADC*4-1:0]       slip_count;

  always #5 divclk = ~divclk;

  fclk_align_ctrl #(
    .NUM_ADC(NUM_ADC), .DESER_W(DESER_W), .PATTERN(PATTERN),
    .SETTLE_CYC(SETTLE_CYC), .LOCK_CNT(LOCK_CNT), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .divclk(divclk), .rst(rst), .retrain(retrain), .fclk_deser(fclk_deser),
    .bitslip(bitslip), .lane_locked(lane_locked), .all_locked(all_locked),
    .align_fail(align_fail), .slip_count(slip_count)
  );

  // Model: each lane is described by run lengths and remaining waits, not by named states.
  int  m_run[NUM_ADC], m_miss[NUM_ADC], m_slips[NUM_ADC], m_settle[NUM_ADC];
  int  m_last[NUM_ADC], m_scount[NUM_ADC];
  bit  m_pulse[NUM_ADC], m_lck[NUM_ADC], m_failed[NUM_ADC];
  bit  m_all;

  logic [7:0] word[NUM_ADC];
  int cyc, n_checks, n_err;
  int last_seen[NUM_ADC], dut_pulses[NUM_ADC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_lane(input int i);
    m_run[i] = 0; m_miss[i] = 0; m_slips[i] = 0; m_settle[i] = 0;
    m_pulse[i] = 0; m_lck[i] = 0; m_failed[i] = 0; m_scount[i] = 0;
  endtask

  task automatic model_step();
    bit all_prev;
    all_prev = 1;
    for (int i = 0; i < NUM_ADC; i++) all_prev &= m_lck[i];
    if (rst) begin
      m_all = 0;
      for (int i = 0; i < NUM_ADC; i++) begin
        clear_lane(i);
        m_last[i] = -1000;
      end
    end else begin
      m_all = all_prev;
      for (int i = 0; i < NUM_ADC; i++) begin
        if (retrain) clear_lane(i);
        else if (m_failed[i]) ;
        else if (m_pulse[i]) begin
          m_pulse[i] = 0;
          if (m_slips[i] == DESER_W) m_failed[i] = 1;
          else m_settle[i] = SETTLE_CYC;
        end else if (m_settle[i] > 0) m_settle[i]--;
        else if (m_lck[i]) begin
          if (word[i] == PATTERN) m_miss[i] = 0;
          else m_miss[i]++;
          if (m_miss[i] == MISS_LIMIT) begin
            m_lck[i] = 0; m_miss[i] = 0; m_slips[i] = 0; m_scount[i] = 0; m_run[i] = 0;
          end
        end else if (word[i] == PATTERN) begin
          m_run[i]++;
          if (m_run[i] == LOCK_CNT) begin
            m_lck[i] = 1; m_run[i] = 0; m_miss[i] = 0;
          end
        end else begin
          m_run[i] = 0;
          if (cyc + 1 - m_last[i] >= SETTLE_CYC + 1) begin
            m_pulse[i] = 1;
            m_slips[i]++;
            if (m_scount[i] < 15) m_scount[i]++;
            m_last[i] = cyc + 1;
          end
        end
      end
    end
  endtask

  task automatic compare();
    logic [NUM_ADC-1:0]   e_bs, e_lk, e_fl;
    logic [NUM_ADC*4-1:0] e_sc;
    for (int i = 0; i < NUM_ADC; i++) begin
      e_bs[i] = m_pulse[i];
      e_lk[i] = m_lck[i];
      e_fl[i] = m_failed[i];
      e_sc[i*4 +: 4] = 4'(m_scount[i]);
    end
    check("bitslip", 32'(bitslip), 32'(e_bs));
    check("lane_locked", 32'(lane_locked), 32'(e_lk));
    check("all_locked", 32'(all_locked), 32'(m_all));
    check("align_fail", 32'(align_fail), 32'(e_fl));
    check("slip_count", 32'(slip_count), 32'(e_sc));
    for (int i = 0; i < NUM_ADC; i++) begin
      if (bitslip[i] === 1'b1) begin
        dut_pulses[i]++;
        if (last_seen[i] >= 0)
          check("slip_gap", 32'(cyc - last_seen[i] >= SETTLE_CYC + 1), 32'd1);
        last_seen[i] = cyc;
      end
    end
  endtask

  task automatic step();
    for (int i = 0; i < NUM_ADC; i++) fclk_deser[i*DESER_W +: DESER_W] = word[i];
    @(posedge divclk);
    model_step();
    #1;
    cyc++;
    if (rst) for (int i = 0; i < NUM_ADC; i++) last_seen[i] = -1;
    compare();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pct[NUM_ADC];
    cyc = 0; n_checks = 0; n_err = 0;
    rst = 1'b1; retrain = 1'b0;
    for (int i = 0; i < NUM_ADC; i++) begin
      word[i] = PATTERN; last_seen[i] = -1; dut_pulses[i] = 0; pct[i] = 100;
    end
    repeat (3) step();
    check("reset_state", {lane_locked, align_fail, all_locked, bitslip}, 32'd0);

    // Both lanes aligned: lock after 4 matches, aggregate one cycle later.
    rst = 1'b0;
    repeat (4) step();
    check("lock_after_4", 32'(lane_locked), 32'h3);
    check("all_lag", 32'(all_locked), 32'd0);
    step();
    check("all_locked_on", 32'(all_locked), 32'd1);
    check("no_slips", 32'(dut_pulses[0] + dut_pulses[1]), 32'd0);

    // Lane 0 misaligned until three slips, then aligned.
    word[0] = 8'h1E;
    dut_pulses[0] = 0;
    for (int k = 0; k < 400 && m_slips[0] < 3; k++) step();
    word[0] = PATTERN;
    repeat (40) step();
    check("three_pulses", 32'(dut_pulses[0]), 32'd3);
    check("slip_count3", 32'(slip_count[3:0]), 32'd3);
    check("relock", 32'(lane_locked), 32'h3);

    // One miss holds lock, two consecutive misses drop it, next mismatch slips.
    word[0] = 8'h3C; step();
    word[0] = PATTERN; repeat (3) step();
    check("one_miss_hold", 32'(lane_locked[0]), 32'd1);
    word[0] = 8'h3C; repeat (2) step();
    check("two_miss_drop", 32'(lane_locked[0]), 32'd0);
    step();
    check("slip_after_drop", 32'(bitslip[0]), 32'd1);
    word[0] = PATTERN;
    repeat (40) step();

    // Lane never matches: 8 slips, sticky failure, lane 1 unaffected.
    word[0] = 8'h00;
    dut_pulses[0] = 0;
    repeat (700) step();
    check("exhaust_pulses", 32'(dut_pulses[0]), 32'd8);
    check("fail_sticky", 32'(align_fail), 32'h1);
    check("other_lane_ok", 32'(lane_locked[1]), 32'd1);

    // Retrain out of failure with the correct pattern.
    word[0] = PATTERN;
    retrain = 1'b1; step();
    retrain = 1'b0;
    check("retrain_fail_clr", 32'(align_fail), 32'd0);
    check("retrain_cnt_clr", 32'(slip_count), 32'd0);
    repeat (4) step();
    check("retrain_lock", 32'(lane_locked), 32'h3);

    // Reset in the middle of a settle window.
    word[0] = 8'h55;
    for (int k = 0; k < 100 && m_settle[0] == 0; k++) step();
    repeat (5) step();
    rst = 1'b1; step();
    check("rst_settle_outs", {slip_count, lane_locked, align_fail, all_locked, bitslip}, 32'd0);
    rst = 1'b0;
    word[0] = PATTERN;
    repeat (5) step();
    check("rst_relock", 32'(lane_locked), 32'h3);

    // Random segments of varying alignment quality with sporadic retrain and reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_ADC; i++) begin
        if (c % 64 == 0) begin
          case ($urandom_range(0, 3))
            0: pct[i] = 0;
            1: pct[i] = 50;
            2: pct[i] = 90;
            default: pct[i] = 100;
          endcase
        end
        word[i] = ($urandom_range(0, 99) < pct[i]) ? PATTERN : 8'($urandom);
      end
      retrain = ($urandom_range(0, 149) == 0);
      rst     = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0; retrain = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
